// File: rtl/sweep_scheduler.sv
// sweep_scheduler: serpentine servo raster sweep with settle, ADC trigger and peak tracking
module sweep_scheduler #(
  parameter int H_STEPS      = 16,
  parameter int V_STEPS      = 8,
  parameter int POS_W        = 8,
  parameter int SETTLE_TICKS = 50,
  parameter int EOC_TIMEOUT  = 255
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             TICK,
  input  logic             ADC_EOC,
  input  logic [11:0]      ADC_DATA,
  output logic             ADC_SOC,
  output logic [POS_W-1:0] POS_H,
  output logic [POS_W-1:0] POS_V,
  output logic [11:0]      MAX_V,
  output logic [POS_W-1:0] BEST_H,
  output logic [POS_W-1:0] BEST_V,
  output logic             BUSY,
  output logic             DONE,
  output logic             TIMEOUT_ERR,
  output logic [2:0]       STAT
);
  localparam int SW = $clog2(SETTLE_TICKS + 1);
  localparam int WW = $clog2(EOC_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, SETTLE, CONVERT, WAIT_EOC, UPDATE, STEP, PARK, PARK_SETTLE} state_t;
  state_t state_q, state_d;
  logic [POS_W-1:0] pos_h_q, pos_h_d, pos_v_q, pos_v_d, best_h_q, best_h_d, best_v_q, best_v_d;
  logic [11:0] max_q, max_d, sample_q, sample_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic dir_q, dir_d, valid_q, valid_d, tout_q, tout_d, done, settle_last, h_more;
  assign settle_last = TICK && cnt_q == SW'(SETTLE_TICKS - 1);
  assign h_more = dir_q ? pos_h_q != '0 : pos_h_q < POS_W'(H_STEPS - 1);
  // next-state, datapath updates and the completion strobe
  always_comb begin
    state_d  = state_q;
    pos_h_d  = pos_h_q;
    pos_v_d  = pos_v_q;
    best_h_d = best_h_q;
    best_v_d = best_v_q;
    max_d    = max_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    wcnt_d   = wcnt_q;
    dir_d    = dir_q;
    tout_d   = tout_q;
    done     = 1'b0;
    case (state_q)
      IDLE: if (START) begin
        {pos_h_d, pos_v_d, best_h_d, best_v_d, max_d, cnt_d} = '0;
        {dir_d, tout_d} = 2'b00;
        state_d = SETTLE;
      end
      SETTLE: if (TICK) begin
        cnt_d   = settle_last ? '0 : cnt_q + 1'b1;
        state_d = settle_last ? CONVERT : SETTLE;
      end
      CONVERT: begin
        wcnt_d  = '0;
        state_d = WAIT_EOC;
      end
      WAIT_EOC: begin
        wcnt_d = wcnt_q + 1'b1;
        if (ADC_EOC) begin
          sample_d = ADC_DATA;
          valid_d  = 1'b1;
          state_d  = UPDATE;
        end else if (wcnt_q == WW'(EOC_TIMEOUT - 1)) begin
          valid_d = 1'b0;
          tout_d  = 1'b1;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        if (valid_q && sample_q > max_q) begin
          max_d    = sample_q;
          best_h_d = pos_h_q;
          best_v_d = pos_v_q;
        end
        state_d = STEP;
      end
      STEP: begin
        cnt_d   = '0;
        state_d = SETTLE;
        if (h_more) pos_h_d = dir_q ? pos_h_q - 1'b1 : pos_h_q + 1'b1;
        else if (pos_v_q < POS_W'(V_STEPS - 1)) begin
          pos_v_d = pos_v_q + 1'b1;
          dir_d   = ~dir_q;
        end else state_d = PARK;
      end
      PARK: begin
        pos_h_d = best_h_q;
        pos_v_d = best_v_q;
        cnt_d   = '0;
        state_d = PARK_SETTLE;
      end
      PARK_SETTLE: if (TICK) begin
        cnt_d   = settle_last ? '0 : cnt_q + 1'b1;
        done    = settle_last;
        state_d = settle_last ? IDLE : PARK_SETTLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      {pos_h_q, pos_v_q, best_h_q, best_v_q, max_q, sample_q, cnt_q, wcnt_q} <= '0;
      {dir_q, valid_q, tout_q} <= 3'b000;
    end else begin
      state_q  <= state_d;
      pos_h_q  <= pos_h_d;
      pos_v_q  <= pos_v_d;
      best_h_q <= best_h_d;
      best_v_q <= best_v_d;
      max_q    <= max_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
      wcnt_q   <= wcnt_d;
      dir_q    <= dir_d;
      tout_q   <= tout_d;
    end
  end
  assign ADC_SOC     = state_q == CONVERT && !RST;
  assign DONE        = done && !RST;
  assign BUSY        = state_q != IDLE;
  assign STAT        = state_q;
  assign POS_H       = pos_h_q;
  assign POS_V       = pos_v_q;
  assign BEST_H      = best_h_q;
  assign BEST_V      = best_v_q;
  assign MAX_V       = max_q;
  assign TIMEOUT_ERR = tout_q;
endmodule
